// File: rtl/aes128_arbiter.sv
// Round-robin, credit-based arbiter sharing one aes128 pipeline among NUM_REQ requesters.
// Define AES128_ARBITER_TAG_CHECK_EN to build the sticky tag/valid mismatch checker (tag_err).
module aes128_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int AES_LATENCY = 21,
    parameter int RSP_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*128-1:0]   req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [127:0]             aes_data_in,
    output logic                     aes_valid_in,
    input  logic [127:0]             aes_data_out,
    input  logic                     aes_valid_out,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [NUM_REQ*128-1:0]   rsp_data,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic                     busy,
    output logic                     tag_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int TAG_N = AES_LATENCY + 1;

    logic [ID_W-1:0]   r_rr;
    logic [CNT_W-1:0]  r_credit [NUM_REQ];
    logic [CNT_W-1:0]  r_count  [NUM_REQ];
    logic [PTR_W-1:0]  r_wptr   [NUM_REQ];
    logic [PTR_W-1:0]  r_rptr   [NUM_REQ];
    logic [127:0]      r_mem    [NUM_REQ][RSP_DEPTH];
    logic [TAG_N-1:0]  r_tag_v;
    logic [ID_W-1:0]   r_tag_id [TAG_N];
    logic              r_aes_valid;
    logic [127:0]      r_aes_data;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_gnt_any;
    logic [ID_W-1:0]    w_gnt_id;
    logic [NUM_REQ-1:0] w_pop;
    logic [NUM_REQ-1:0] w_wr;
    logic               w_exit_v;
    logic [ID_W-1:0]    w_exit_id;

    // First eligible requester at or after rr wins; reset forces no grant.
    always_comb begin
        int idx;
        idx       = 0;
        w_grant   = '0;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_rr) + k) % NUM_REQ;
            if (reset_n && !w_gnt_any && req_valid[idx] && (r_credit[idx] != '0)) begin
                w_grant[idx] = 1'b1;
                w_gnt_any    = 1'b1;
                w_gnt_id     = ID_W'(idx);
            end
        end
    end

    assign w_exit_v  = r_tag_v[TAG_N-1];
    assign w_exit_id = r_tag_id[TAG_N-1];

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_req
            assign w_wr[g]                 = aes_valid_out && w_exit_v && (w_exit_id == ID_W'(g));
            assign rsp_valid[g]            = (r_count[g] != '0);
            assign rsp_data[g*128 +: 128]  = r_mem[g][r_rptr[g]];
        end
    endgenerate

    assign w_pop        = rsp_valid & rsp_ready;
    assign req_ready    = w_grant;
    assign aes_valid_in = r_aes_valid;
    assign aes_data_in  = r_aes_data;
    assign busy         = (|r_tag_v) | r_aes_valid | (|rsp_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr        <= '0;
            r_aes_valid <= 1'b0;
            r_aes_data  <= '0;
            r_tag_v     <= '0;
            for (int t = 0; t < TAG_N; t++) r_tag_id[t] <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_credit[i] <= CNT_W'(RSP_DEPTH);
                r_count[i]  <= '0;
                r_wptr[i]   <= '0;
                r_rptr[i]   <= '0;
            end
        end else begin
            r_aes_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_aes_data <= req_data[int'(w_gnt_id)*128 +: 128];
                r_rr       <= (int'(w_gnt_id) == NUM_REQ - 1) ? '0 : w_gnt_id + ID_W'(1);
            end
            // Tag enters with the grant so it leaves exactly when the block returns.
            r_tag_v     <= {r_tag_v[TAG_N-2:0], w_gnt_any};
            r_tag_id[0] <= w_gnt_id;
            for (int t = 1; t < TAG_N; t++) r_tag_id[t] <= r_tag_id[t-1];
            for (int i = 0; i < NUM_REQ; i++) begin
                unique case ({w_grant[i], w_pop[i]})
                    2'b10:   r_credit[i] <= r_credit[i] - CNT_W'(1);
                    2'b01:   r_credit[i] <= r_credit[i] + CNT_W'(1);
                    default: r_credit[i] <= r_credit[i];
                endcase
                unique case ({w_wr[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
                    2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
                    default: r_count[i] <= r_count[i];
                endcase
                if (w_wr[i])  r_wptr[i] <= r_wptr[i] + PTR_W'(1);
                if (w_pop[i]) r_rptr[i] <= r_rptr[i] + PTR_W'(1);
            end
        end
    end

    // Response storage is data only; validity lives in r_count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_wr[i]) r_mem[i][r_wptr[i]] <= aes_data_out;
        end
    end

`ifdef AES128_ARBITER_TAG_CHECK_EN
    logic r_tag_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_err <= 1'b0;
        end else if (aes_valid_out != w_exit_v) begin
            r_tag_err <= 1'b1;
        end
    end

    assign tag_err = r_tag_err;
`else
    assign tag_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes128_arbiter.sv
// Directed bench for aes128_arbiter (2 requesters) with a simple XOR-key aes128 latency model.
module tb_aes128_arbiter;

    localparam int L = 21;
    localparam logic [127:0] KEY = 128'h5A5A_5A5A_0F0F_0F0F_A5A5_A5A5_F0F0_F0F0;
`ifdef AES128_ARBITER_TAG_CHECK_EN
    localparam logic EXP_TE = 1'b1;
`else
    localparam logic EXP_TE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   req_valid;
    logic [127:0] req_data0, req_data1;
    logic [255:0] req_data;
    logic [1:0]   req_ready;
    logic [127:0] aes_data_in;
    logic         aes_valid_in;
    logic [127:0] aes_data_out;
    logic         aes_valid_out;
    logic [1:0]   rsp_valid;
    logic [255:0] rsp_data;
    logic [127:0] rsp_data0, rsp_data1;
    logic [1:0]   rsp_ready;
    logic         busy;
    logic         tag_err;
    logic         inj;

    logic [L-1:0] pv = '0;
    logic [127:0] pd [L];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [127:0] da [4];
    logic [127:0] db [4];
    logic [127:0] gexp [4];
    logic [127:0] cb, dbase;

    assign req_data  = {req_data1, req_data0};
    assign rsp_data0 = rsp_data[127:0];
    assign rsp_data1 = rsp_data[255:128];

    aes128_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .aes_data_in   (aes_data_in),
        .aes_valid_in  (aes_valid_in),
        .aes_data_out  (aes_data_out),
        .aes_valid_out (aes_valid_out),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_ready     (rsp_ready),
        .busy          (busy),
        .tag_err       (tag_err)
    );

    always #5 clk = ~clk;

    // aes128 stand-in: fixed latency L, output = input ^ KEY; never reset.
    always @(posedge clk) begin
        pv    <= {pv[L-2:0], aes_valid_in};
        pd[0] <= aes_data_in ^ KEY;
        for (int j = 1; j < L; j++) pd[j] <= pd[j-1];
    end
    assign aes_valid_out = pv[L-1] | inj;
    assign aes_data_out  = pd[L-1];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b11;
        req_data0 = '0;
        req_data1 = '0;
        rsp_ready = 2'b00;
        inj       = 1'b0;
        for (int k = 0; k < 4; k++) begin
            da[k] = 128'hAAAA_0000_0000_0000_0000_0000_0000_0000 + 128'(k);
            db[k] = 128'hBBBB_0000_0000_0000_0000_0000_0000_0000 + 128'(k);
        end
        cb    = 128'hCCCC_0000_0000_0000_0000_0000_0000_0000;
        dbase = 128'hDDDD_0000_0000_0000_0000_0000_0000_0000;

        // Reset state with requests pending
        repeat (3) @(posedge clk);
        #2;
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_aes_valid", aes_valid_in, 1'b0);
        check("rst_aes_data", aes_data_in, '0);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_tag_err", tag_err, 1'b0);

        // Both requesters every cycle: grants alternate 0,1,0,1
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        rsp_ready = 2'b11;
        cyc       = 0;
        for (int k = 0; k < 4; k++) begin
            req_data0 = da[k];
            req_data1 = db[k];
            gexp[k]   = (k % 2 == 0) ? da[k] : db[k];
            #1;
            check("rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) begin
                check("rr_aes_valid", aes_valid_in, 1'b1);
                check("rr_aes_data", aes_data_in, gexp[k-1]);
            end
            tick();
        end
        req_valid = 2'b00;
        #1;
        check("rr_ready_idle", req_ready, 2'b00);
        check("rr_aes_data_last", aes_data_in, gexp[3]);
        tick();
        #1;
        check("rr_aes_valid_off", aes_valid_in, 1'b0);
        check("rr_aes_data_hold", aes_data_in, gexp[3]);
        check("rr_busy_inflight", busy, 1'b1);
        wait_to(22);
        #1;
        check("lat_rsp_not_yet", rsp_valid, 2'b00);
        tick();
        #1;
        check("lat_rsp0_v", rsp_valid, 2'b01);
        check("lat_rsp0_d", rsp_data0, da[0] ^ KEY);
        tick();
        #1;
        check("ord_rsp1_v", rsp_valid, 2'b10);
        check("ord_rsp1_d", rsp_data1, db[1] ^ KEY);
        tick();
        #1;
        check("ord_rsp2_v", rsp_valid, 2'b01);
        check("ord_rsp2_d", rsp_data0, da[2] ^ KEY);
        tick();
        #1;
        check("ord_rsp3_v", rsp_valid, 2'b10);
        check("ord_rsp3_d", rsp_data1, db[3] ^ KEY);
        tick();
        #1;
        check("ord_empty", rsp_valid, 2'b00);
        check("ord_busy_idle", busy, 1'b0);

        // Requester 0 alone, no pops: four grants then stall until a pop
        tick();
        cyc       = 0;
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        for (int k = 0; k < 4; k++) begin
            req_data0 = cb + 128'(k);
            #1;
            check("cred_grant", req_ready, 2'b01);
            tick();
        end
        #1;
        check("cred_exhausted", req_ready, 2'b00);
        wait_to(30);
        #1;
        check("cred_still_zero", req_ready, 2'b00);
        check("cred_fifo_v", rsp_valid, 2'b01);
        check("cred_fifo_head", rsp_data0, cb ^ KEY);
        rsp_ready = 2'b01;
        #1;
        check("cred_pop_cycle", req_ready, 2'b00);
        tick();
        rsp_ready = 2'b00;
        req_data0 = cb + 128'd4;
        #1;
        check("cred_restored", req_ready, 2'b01);
        check("cred_next_head", rsp_data0, (cb + 128'd1) ^ KEY);
        tick();
        #1;
        check("cred_one_only", req_ready, 2'b00);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (40) tick();
        #1;
        check("drain1_rsp", rsp_valid, 2'b00);
        check("drain1_busy", busy, 1'b0);

        // Requester 1: simultaneous grant and pop at credit 1
        tick();
        cyc       = 0;
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        for (int k = 0; k < 3; k++) begin
            req_data1 = dbase + 128'(k);
            #1;
            check("gp_fill", req_ready, 2'b10);
            tick();
        end
        req_valid = 2'b00;
        wait_to(30);
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        req_data1 = dbase + 128'd3;
        #1;
        check("gp_fifo_v", rsp_valid, 2'b10);
        check("gp_grant_pop", req_ready, 2'b10);
        tick();
        rsp_ready = 2'b00;
        req_data1 = dbase + 128'd4;
        #1;
        check("gp_credit_kept", req_ready, 2'b10);
        check("gp_head", rsp_data1, (dbase + 128'd1) ^ KEY);
        tick();
        #1;
        check("gp_credit_zero", req_ready, 2'b00);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (40) tick();
        #1;
        check("drain2_busy", busy, 1'b0);

        // Stray aes_valid_out with empty pipeline
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        #1;
        check("stray_tag_err", tag_err, EXP_TE);
        check("stray_discard", rsp_valid, 2'b00);
        repeat (3) tick();
        #1;
        check("stray_sticky", tag_err, EXP_TE);
        check("stray_busy", busy, 1'b0);

        // Reset with five blocks in flight
        tick();
        cyc       = 0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 5; k++) begin
            req_data0 = da[k % 4];
            req_data1 = db[k % 4];
            #1;
            check("mid_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        req_valid = 2'b00;
        reset_n   = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rsp", rsp_valid, 2'b00);
        check("mid_rst_aes_v", aes_valid_in, 1'b0);
        check("mid_rst_aes_d", aes_data_in, '0);
        check("mid_rst_tag_err", tag_err, 1'b0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 35; k++) begin
            #1;
            check("late_discard", rsp_valid, 2'b00);
            tick();
        end
        #1;
        check("late_busy", busy, 1'b0);
        check("late_tag_err", tag_err, EXP_TE);
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        for (int k = 0; k < 4; k++) begin
            req_data0 = cb + 128'(k);
            #1;
            check("post_rst_credit", req_ready, 2'b01);
            tick();
        end
        #1;
        check("post_rst_credit_end", req_ready, 2'b00);
        req_valid = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes128_arbiter.md
AES128_ARBITER -- requirements
Module: aes128_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, number of requesters sharing one aes128 pipeline (range 2..8).
REQ-002 The block SHALL have parameter AES_LATENCY, default 21, cycles from aes128 valid_in to valid_out.
REQ-003 The block SHALL have parameter RSP_DEPTH, default 4, per-requester response FIFO entries (power of 2, >=2).
REQ-004 clk  in  1  single clock, all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester block offered.
REQ-007 req_data  in  NUM_REQ x 128  per-requester plaintext block.
REQ-008 req_ready  out  NUM_REQ  per-requester grant; transfer when req_valid[i] & req_ready[i].
REQ-009 aes_data_in  out  128  block to aes128 data_in.
REQ-010 aes_valid_in  out  1  to aes128 valid_in.
REQ-011 aes_data_out  in  128  from aes128 data_out.
REQ-012 aes_valid_out  in  1  from aes128 valid_out.
REQ-013 rsp_valid  out  NUM_REQ  response FIFO i non-empty.
REQ-014 rsp_data  out  NUM_REQ x 128  head of response FIFO i.
REQ-015 rsp_ready  in  NUM_REQ  pop FIFO i when rsp_valid[i] & rsp_ready[i].
REQ-016 busy  out  1  any block in flight or any response FIFO non-empty.
REQ-017 tag_err  out  1  sticky tag-mismatch flag (see Configuration).

Function
REQ-018 Each requester SHALL hold credit[i] = RSP_DEPTH minus blocks in flight for i minus FIFO i occupancy.
REQ-019 Requester i is eligible iff req_valid[i] & credit[i] > 0; at most one requester SHALL be granted per cycle.
REQ-020 Arbitration SHALL be round-robin: search starts at pointer rr; after a grant to i, rr <= (i+1) mod NUM_REQ; with no grant rr SHALL hold.
REQ-021 req_ready SHALL be combinational from req_valid, credit and rr, and one-hot or zero.
REQ-022 On a grant to i, the next cycle SHALL drive aes_valid_in=1, aes_data_in=req_data[i]; otherwise aes_valid_in=0 and aes_data_in holds.
REQ-023 A tag shift register of depth AES_LATENCY+1 SHALL carry {valid, id} for each grant, aligned so the tag exits in the cycle aes_valid_out returns that block.
REQ-024 On aes_valid_out with valid exit tag id=k, aes_data_out SHALL be written to FIFO k that cycle; rsp_valid[k] rises next cycle.
REQ-025 aes_valid_out with no valid exit tag SHALL be discarded.
REQ-026 Credit: grant decrements, pop increments, simultaneous grant and pop leaves credit unchanged; credit never exceeds RSP_DEPTH nor goes below 0.
REQ-027 FIFO overflow SHALL be impossible by REQ-019; a write to a full FIFO SHALL never occur.
REQ-028 Simultaneous FIFO write and pop on the same FIFO SHALL both take effect; order per requester SHALL be preserved.
REQ-029 busy SHALL be 1 iff any tag valid bit, any aes_valid_in, or any rsp_valid is 1.
REQ-030 Grant-to-FIFO-write latency SHALL be exactly AES_LATENCY+1 cycles.

Reset
REQ-031 While reset_n=0: req_ready=0, aes_valid_in=0, aes_data_in=0, rsp_valid=0, busy=0, tag_err=0, rr=0, credit[i]=RSP_DEPTH, tags and FIFOs empty.
REQ-032 Reset mid-operation SHALL drop all in-flight and queued blocks; post-reset aes outputs with no valid tag SHALL be discarded.

Configuration
REQ-033 With AES128_ARBITER_TAG_CHECK_EN defined, tag_err SHALL set on aes_valid_out without valid exit tag, or valid exit tag without aes_valid_out, and clear only on reset.
REQ-034 Without AES128_ARBITER_TAG_CHECK_EN, tag_err SHALL be tied 0 and no checker logic compiled; REQ-025 discard still applies.

Verification
REQ-035 Both requesters valid every cycle, rsp_ready=1, rr=0 -> grants alternate 0,1,0,1; outputs return in order after 22 cycles each.
REQ-036 Requester 0 only, rsp_ready[0]=0 -> exactly 4 grants, then req_ready[0]=0 until one pop restores one grant.
REQ-037 Grant and pop on requester 1 in same cycle with credit 1 -> credit stays 1, grant next cycle still allowed.
REQ-038 reset_n pulsed low with 5 blocks in flight -> rsp_valid stays 0, busy=0, credits 4, late aes_valid_out discarded.
REQ-039 Macro defined, inject aes_valid_out=1 with pipeline empty -> tag_err=1 next cycle and stays 1; macro undefined -> tag_err=0.
